rv32_pc_v3: RTL and testbench

Parametrised program-counter unit for the RV32 fetch stage, the next generation of the PC block. It computes the next fetch address for sequential flow, JAL, JALR and conditional branches, and drives the IF/ID flush. It also holds a redirect that arrives while fetch is frozen instead of dropping it, and traps misaligned targets to a configurable vector. It sits between the execute-stage branch resolution and the instruction-memory address port.

---
 rtl/rv32_pc_v3.sv | 155 +++++++++++++++
 tb/tb_rv32_pc_v3.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rv32_pc_v3.sv
// -----------------------------------------------------------------------------
// rv32_pc_v3 -- program-counter unit for the RV32 fetch stage.
//
// Computes the next fetch address for sequential flow, JAL, JALR and
// conditional branches, registers the IF/ID flush, keeps a redirect that
// arrives while fetch is frozen, and traps misaligned targets to TRAP_VECTOR.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   enable            PC run enable (halt = ~enable)
//   busy, stall       either one freezes the PC
//   branch, pc_opsel  redirect request and kind (0 JAL, 1 JALR, 2..7 branch)
//   execute_pc        PC of the instruction entering execute
//   code_bus          instruction word in execute (immediate source)
//   reg_s1            rs1 value for JALR
//   pc_out            current fetch address
//   return_addr       pc+4 delayed by RET_DELAY cycles
//   flush             registered IF/ID flush
//   halt              combinational ~enable
//   redirect_pending  a captured redirect is waiting for the PC to advance
//   misalign_trap     one-cycle pulse on a misaligned redirect target
//   trap_pc           last offending target, held until the next trap
//
// Handshake: there is no valid/ready pair. branch is a single-cycle request
// qualified by nothing; it is always accepted, either applied directly (PC
// advancing) or captured into the pending slot (PC frozen), newest wins.
// -----------------------------------------------------------------------------
module rv32_pc_v3 #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
   parameter int              RET_DELAY    = 3,   // legal range 1..8
   parameter bit              ALIGN_CHECK  = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            enable,
   input  logic            busy,
   input  logic            stall,
   input  logic            branch,
   input  logic [2:0]      pc_opsel,
   input  logic [XLEN-1:0] execute_pc,
   input  logic [31:0]     code_bus,
   input  logic [XLEN-1:0] reg_s1,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] return_addr,
   output logic            flush,
   output logic            halt,
   output logic            redirect_pending,
   output logic            misalign_trap,
   output logic [XLEN-1:0] trap_pc
);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pend_pc_q, pend_pc_d;
   logic            pend_q, pend_d;
   logic [XLEN-1:0] trap_pc_q, trap_pc_d;
   logic            trap_q, trap_d;
   logic            flush_q;
   logic [XLEN-1:0] exec_pc_q;
   logic [XLEN-1:0] ret_q [RET_DELAY];

   logic            adv;
   logic [XLEN-1:0] imm_i, imm_uj, imm_sb;
   logic [XLEN-1:0] jalr_sum, tgt, redir_pc;
   logic            mis;

   assign adv = enable & ~busy & ~stall;

   assign imm_i  = {{(XLEN-12){code_bus[31]}}, code_bus[31:20]};
   assign imm_uj = {{(XLEN-21){code_bus[31]}}, code_bus[31], code_bus[19:12],
                    code_bus[20], code_bus[30:21], 1'b0};
   assign imm_sb = {{(XLEN-13){code_bus[31]}}, code_bus[31], code_bus[7],
                    code_bus[30:25], code_bus[11:8], 1'b0};

   assign jalr_sum = reg_s1 + imm_i;

   always_comb begin
      tgt = exec_pc_q + imm_sb;
      case (pc_opsel)
         3'd0:    tgt = exec_pc_q + imm_uj;
         3'd1:    tgt = {jalr_sum[XLEN-1:1], 1'b0};
         default: tgt = exec_pc_q + imm_sb;
      endcase
   end

   // JALR clears bit 0, so a JALR target can still trap through bit 1.
   assign mis      = ALIGN_CHECK ? (tgt[1:0] != 2'b00) : 1'b0;
   assign redir_pc = mis ? TRAP_VECTOR : tgt;

   always_comb begin
      pc_d      = pc_q;
      pend_d    = pend_q;
      pend_pc_d = pend_pc_q;
      trap_pc_d = trap_pc_q;
      // A misaligned target traps whether it is applied now or captured.
      trap_d    = branch & mis;
      if (branch && mis) begin
         trap_pc_d = tgt;
      end
      if (adv) begin
         pend_d = 1'b0;
         if (branch) begin
            pc_d = redir_pc;
         end else if (pend_q) begin
            pc_d = pend_pc_q;
         end else begin
            pc_d = pc_q + XLEN'(4);
         end
      end else if (branch) begin
         // Frozen: remember the newest redirect, replacing any older one.
         pend_d    = 1'b1;
         pend_pc_d = redir_pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= RESET_VECTOR;
         pend_q    <= 1'b0;
         pend_pc_q <= '0;
         trap_q    <= 1'b0;
         trap_pc_q <= '0;
         flush_q   <= 1'b0;
         exec_pc_q <= '0;
      end else begin
         pc_q      <= pc_d;
         pend_q    <= pend_d;
         pend_pc_q <= pend_pc_d;
         trap_q    <= trap_d;
         trap_pc_q <= trap_pc_d;
         flush_q   <= branch;
         exec_pc_q <= execute_pc;
      end
   end

   // Link-address delay line; shifts every cycle regardless of adv.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RET_DELAY; i++) ret_q[i] <= '0;
      end else begin
         ret_q[0] <= pc_q + XLEN'(4);
         for (int i = 1; i < RET_DELAY; i++) ret_q[i] <= ret_q[i-1];
      end
   end

   assign pc_out           = pc_q;
   assign return_addr      = ret_q[RET_DELAY-1];
   assign flush            = flush_q;
   assign halt             = ~enable;
   assign redirect_pending = pend_q;
   assign misalign_trap    = trap_q;
   assign trap_pc          = trap_pc_q;

endmodule

// File: tb/tb_rv32_pc_v3.sv
// -----------------------------------------------------------------------------
// Bench for rv32_pc_v3 with default parameters (RET_DELAY = 3,
// TRAP_VECTOR = 0x100, RESET_VECTOR = 0). The driver applies one cycle of
// inputs and pushes the hand-computed post-edge outputs into exp_q; the
// monitor pops and compares on each falling edge.
// -----------------------------------------------------------------------------
module tb_rv32_pc_v3;

   localparam int RD = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b1, busy = 1'b0, stall = 1'b0, branch = 1'b0;
   logic [2:0]  pc_opsel = 3'd0;
   logic [31:0] execute_pc = 32'h100, code_bus = 32'h0, reg_s1 = 32'h0;
   logic [31:0] pc_out, return_addr, trap_pc;
   logic        flush, halt, redirect_pending, misalign_trap;

   rv32_pc_v3 dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .busy(busy), .stall(stall),
      .branch(branch), .pc_opsel(pc_opsel), .execute_pc(execute_pc),
      .code_bus(code_bus), .reg_s1(reg_s1), .pc_out(pc_out),
      .return_addr(return_addr), .flush(flush), .halt(halt),
      .redirect_pending(redirect_pending), .misalign_trap(misalign_trap),
      .trap_pc(trap_pc)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [31:0] pc;
      logic [31:0] ret;
      logic [31:0] tpc;
      logic        flush;
      logic        pend;
      logic        trap;
      logic        halt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Link-address model: pc+4 of each cycle, shifted RD deep.
   logic [31:0] ret_m [RD];
   logic [31:0] prev_pc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("pc_out", pc_out, e.pc);
         chk("return_addr", return_addr, e.ret);
         chk("trap_pc", trap_pc, e.tpc);
         chk("flush", {31'b0, flush}, {31'b0, e.flush});
         chk("redirect_pending", {31'b0, redirect_pending}, {31'b0, e.pend});
         chk("misalign_trap", {31'b0, misalign_trap}, {31'b0, e.trap});
         chk("halt", {31'b0, halt}, {31'b0, e.halt});
      end
   end

   // ---------------- driver tasks ----------------
   // Called at negedge+1; returns at the next negedge+1.
   task automatic cyc(input logic en, input logic bsy, input logic stl,
                      input logic br, input logic [2:0] op,
                      input logic [31:0] cb, input logic [31:0] rs1,
                      input logic [31:0] e_pc, input logic e_flush,
                      input logic e_pend, input logic e_trap,
                      input logic [31:0] e_tpc);
      exp_t e;
      enable = en; busy = bsy; stall = stl; branch = br;
      pc_opsel = op; code_bus = cb; reg_s1 = rs1;
      @(posedge clk); #1;
      for (int i = RD-1; i > 0; i--) ret_m[i] = ret_m[i-1];
      ret_m[0] = prev_pc + 32'd4;
      prev_pc  = e_pc;
      e.pc = e_pc; e.ret = ret_m[RD-1]; e.tpc = e_tpc;
      e.flush = e_flush; e.pend = e_pend; e.trap = e_trap; e.halt = ~en;
      exp_q.push_back(e);
      @(negedge clk); #1;
   endtask

   task automatic do_reset();
      exp_t e;
      enable = 1'b1; busy = 1'b0; stall = 1'b0; branch = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < RD; i++) ret_m[i] = 32'h0;
      prev_pc = 32'h0;
      e.pc = 32'h0; e.ret = 32'h0; e.tpc = 32'h0;
      e.flush = 1'b0; e.pend = 1'b0; e.trap = 1'b0; e.halt = 1'b0;
      exp_q.push_back(e);
      @(negedge clk); #1;
      rst_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   localparam logic [31:0] JAL_P20   = 32'h0200006F; // JAL +0x20
   localparam logic [31:0] JALR_0    = 32'h00008067; // JALR imm 0
   localparam logic [31:0] JALR_M4   = 32'hFFC00067; // JALR imm -4
   localparam logic [31:0] SB_P2     = 32'h00000163; // branch +2 (misaligned)
   localparam logic [31:0] SB_P8     = 32'h00000463; // branch +8
   localparam logic [31:0] SB_M4096  = 32'h80000063; // branch -4096

   initial begin
      for (int i = 0; i < RD; i++) ret_m[i] = 32'h0;
      prev_pc = 32'h0;
      @(negedge clk); #1;
      do_reset();
      //  en bsy stl br op  code      rs1        pc            fl pd tr trap_pc
      cyc(1, 0, 0, 0, 0, 32'h0,    32'h0,     32'h4,        0, 0, 0, 32'h0);
      cyc(1, 0, 0, 0, 0, 32'h0,    32'h0,     32'h8,        0, 0, 0, 32'h0);
      cyc(1, 0, 0, 0, 0, 32'h0,    32'h0,     32'hC,        0, 0, 0, 32'h0);
      cyc(1, 0, 0, 0, 0, 32'h0,    32'h0,     32'h10,       0, 0, 0, 32'h0);
      // JAL from execute_pc 0x100, +0x20
      cyc(1, 0, 0, 1, 0, JAL_P20,  32'h0,     32'h120,      1, 0, 0, 32'h0);
      cyc(1, 0, 0, 0, 0, 32'h0,    32'h0,     32'h124,      0, 0, 0, 32'h0);
      // JALR to 0x202 traps to 0x100
      cyc(1, 0, 0, 1, 1, JALR_0,   32'h203,   32'h100,      1, 0, 1, 32'h202);
      cyc(1, 0, 0, 0, 0, 32'h0,    32'h0,     32'h104,      0, 0, 0, 32'h202);
      // Branch captured while busy, applied when busy drops
      cyc(1, 1, 0, 1, 1, JALR_0,   32'h400,   32'h104,      1, 1, 0, 32'h202);
      cyc(1, 1, 0, 0, 0, 32'h0,    32'h0,     32'h104,      0, 1, 0, 32'h202);
      cyc(1, 0, 0, 0, 0, 32'h0,    32'h0,     32'h400,      0, 0, 0, 32'h202);
      cyc(1, 0, 0, 0, 0, 32'h0,    32'h0,     32'h404,      0, 0, 0, 32'h202);
      // Two branches while stalled: newest (0x800) wins
      cyc(1, 0, 1, 1, 1, JALR_0,   32'h400,   32'h404,      1, 1, 0, 32'h202);
      cyc(1, 0, 1, 1, 1, JALR_0,   32'h800,   32'h404,      1, 1, 0, 32'h202);
      cyc(1, 0, 0, 0, 0, 32'h0,    32'h0,     32'h800,      0, 0, 0, 32'h202);
      // Disabled: misaligned SB target 0x102 traps while frozen
      cyc(0, 0, 0, 1, 2, SB_P2,    32'h0,     32'h800,      1, 1, 1, 32'h102);
      // Branch to 0x108 overrides the pending trap redirect
      cyc(1, 0, 0, 1, 3, SB_P8,    32'h0,     32'h108,      1, 0, 0, 32'h102);
      cyc(1, 0, 0, 0, 0, 32'h0,    32'h0,     32'h10C,      0, 0, 0, 32'h102);
      // Negative offsets wrap silently
      cyc(1, 0, 0, 1, 7, SB_M4096, 32'h0,     32'hFFFFF100, 1, 0, 0, 32'h102);
      cyc(1, 0, 0, 1, 1, JALR_M4,  32'h0,     32'hFFFFFFFC, 1, 0, 0, 32'h102);
      cyc(1, 0, 0, 0, 0, 32'h0,    32'h0,     32'h0,        0, 0, 0, 32'h102);
      cyc(1, 0, 0, 0, 0, 32'h0,    32'h0,     32'h4,        0, 0, 0, 32'h102);
      // Pending redirect lost across reset
      cyc(1, 1, 0, 1, 1, JALR_0,   32'h400,   32'h4,        1, 1, 0, 32'h102);
      do_reset();
      cyc(1, 0, 0, 0, 0, 32'h0,    32'h0,     32'h4,        0, 0, 0, 32'h0);
      cyc(1, 0, 0, 0, 0, 32'h0,    32'h0,     32'h8,        0, 0, 0, 32'h0);

      // Let the monitor drain the queue, bounded.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain left=%0d expected=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
